// File: rtl/y_scale_pkg.sv
// Shared widths, screen limits and Q11.4 fixed-point constants for the y-scale
// mapping path; the external ROM wrapper uses the same definitions.
package y_scale_pkg;

    localparam int unsigned ADDR_WIDTH   = 11;
    localparam int unsigned DATA_WIDTH   = 15;
    localparam int unsigned Y_MAX        = 1079;
    localparam int unsigned X_MAX        = 1919;
    localparam int unsigned FRAC_WIDTH   = 4;
    localparam int unsigned ROUND_CONST  = 8;

    localparam int unsigned COORD_WIDTH  = 11;
    localparam int unsigned OFFSET_WIDTH = 12;
    localparam int unsigned SUM_WIDTH    = 13;

    typedef logic [COORD_WIDTH-1:0]      coord_t;
    typedef logic signed [SUM_WIDTH-1:0] row_sum_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   clip;
        logic   last;
    } pixel_t;

    typedef struct packed {
        coord_t row;
        logic   clip;
    } row_clamp_t;

    // Saturate a signed row sum into [0, y_max] and flag whether it was clamped.
    function automatic row_clamp_t clamp_row(input row_sum_t y, input coord_t y_max);
        row_clamp_t res;
        if (y[SUM_WIDTH-1]) begin
            res.row  = '0;
            res.clip = 1'b1;
        end else if (y > row_sum_t'({1'b0, y_max})) begin
            res.row  = y_max;
            res.clip = 1'b1;
        end else begin
            res.row  = y[COORD_WIDTH-1:0];
            res.clip = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/y_map_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; holds mapped pixels until
// the downstream consumer accepts them.
module y_map_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full, empty, do_push, do_pop;

    assign full    = (count_q == CNT_WIDTH'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/y_scale_map.sv
// Maps ADC sample codes to screen points: ROM lookup of the Q11.4 row, rounding,
// per-sweep vertical offset, clamping, column counting and output buffering.
module y_scale_map #(
    parameter int unsigned ADDR_WIDTH = y_scale_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = y_scale_pkg::DATA_WIDTH,
    parameter int unsigned Y_MAX      = y_scale_pkg::Y_MAX,
    parameter int unsigned X_MAX      = y_scale_pkg::X_MAX,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ADDR_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic signed [11:0]    cfg_y_offset,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [10:0]           m_x,
    output logic [10:0]           m_y,
    output logic                  m_last,
    output logic                  m_clip
);

    import y_scale_pkg::*;

    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_WIDTH = CNT_WIDTH + 1;
    localparam int unsigned RND_WIDTH = DATA_WIDTH + 1;

    logic                 v1_q, v1_d;
    logic                 last1_q, last1_d;
    logic                 rdy_en_q;
    coord_t               x_cnt_q, x_cnt_d;
    row_sum_t             offset_q, offset_d;
    row_sum_t             cfg_offset_ext;

    logic [CNT_WIDTH-1:0] fifo_count;
    logic [RND_WIDTH-1:0] rnd_shift;
    row_sum_t             row_ext;
    row_sum_t             y_sum;
    row_clamp_t           clamp;
    pixel_t               push_pix;
    pixel_t               head_pix;
    logic                 accept, push, pop;

    assign rom_addr = s_data;

    // Stage 1 plus buffered entries must leave room; rdy_en_q holds ready low
    // for the first cycle after reset.
    assign s_ready = rdy_en_q &&
                     ((OCC_WIDTH'(fifo_count) + OCC_WIDTH'(v1_q)) < OCC_WIDTH'(FIFO_DEPTH));
    assign accept  = s_valid && s_ready;
    assign push    = v1_q;

    assign cfg_offset_ext = row_sum_t'(cfg_y_offset);
    assign rnd_shift      = (RND_WIDTH'(rom_rd_data) + RND_WIDTH'(ROUND_CONST)) >> FRAC_WIDTH;
    assign row_ext        = row_sum_t'(rnd_shift);
    assign y_sum          = row_ext + offset_q;
    assign clamp          = clamp_row(y_sum, coord_t'(Y_MAX));

    assign push_pix = '{x: x_cnt_q, y: clamp.row, clip: clamp.clip, last: last1_q};

    // The new offset is taken on the edge that writes the sweep's last point,
    // so a following sweep starting on the very next cycle already sees it.
    always_comb begin
        v1_d     = accept;
        last1_d  = accept && s_last;
        x_cnt_d  = x_cnt_q;
        offset_d = offset_q;
        if (push) begin
            if (last1_q || (x_cnt_q == coord_t'(X_MAX))) begin
                x_cnt_d = '0;
            end else begin
                x_cnt_d = x_cnt_q + 1'b1;
            end
            if (last1_q) begin
                offset_d = cfg_offset_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            rdy_en_q <= 1'b0;
            x_cnt_q  <= '0;
            offset_q <= cfg_offset_ext;
        end else begin
            v1_q     <= v1_d;
            last1_q  <= last1_d;
            rdy_en_q <= 1'b1;
            x_cnt_q  <= x_cnt_d;
            offset_q <= offset_d;
        end
    end

    y_map_fifo #(
        .WIDTH($bits(pixel_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .push_data_i(push_pix),
        .pop_i      (pop),
        .head_o     (head_pix),
        .count_o    (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid && m_ready;

    // Outputs read as zero while empty so stale storage never shows.
    assign m_x    = m_valid ? head_pix.x    : '0;
    assign m_y    = m_valid ? head_pix.y    : '0;
    assign m_last = m_valid ? head_pix.last : 1'b0;
    assign m_clip = m_valid ? head_pix.clip : 1'b0;

endmodule

// File: doc/y_scale_map.md
Y_SCALE_MAP -- requirements
Module: y_scale_map

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: sample code width and y-scale ROM address width.
REQ-002 Parameter DATA_WIDTH, default 15: ROM word width, unsigned Q11.4 scaled row value.
REQ-003 Parameter Y_MAX, default 1079: highest legal screen row.
REQ-004 Parameter X_MAX, default 1919: highest legal screen column.
REQ-005 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two and at least 4.
REQ-006 Port clk, input, 1: the single clock.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port s_valid / s_ready, input / output, 1 each: sample handshake.
REQ-009 Port s_data, input, ADDR_WIDTH: ADC sample code.
REQ-010 Port s_last, input, 1: last sample of the current sweep.
REQ-011 Port cfg_y_offset, input, 12, signed: vertical position offset in rows.
REQ-012 Port rom_addr, output, ADDR_WIDTH: address to the y-scale ROM, which has a 1-cycle registered read and no enable.
REQ-013 Port rom_rd_data, input, DATA_WIDTH: ROM read data.
REQ-014 Port m_valid / m_ready, output / input, 1 each: pixel handshake.
REQ-015 Port m_x, output, 11: screen column.
REQ-016 Port m_y, output, 11: screen row.
REQ-017 Port m_last, output, 1: last point of the sweep.
REQ-018 Port m_clip, output, 1: the row was clamped.

Function
REQ-019 A sample is accepted on a cycle with s_valid=1 and s_ready=1.
REQ-020 rom_addr SHALL equal s_data combinationally, so ROM data for an accepted sample arrives on the next cycle.
REQ-021 A stage-1 valid bit v1 SHALL be set on the cycle after each accept, together with that sample's s_last.
REQ-022 s_ready SHALL be 1 only when fifo_count + v1 < FIFO_DEPTH, computed from registered state only.
REQ-023 s_ready SHALL NOT depend combinationally on m_ready.
REQ-024 When v1=1, the block SHALL compute r = (rom_rd_data + 8) >> 4, zero-extended to 13 bits.
REQ-025 It SHALL then compute y = r + offset_q, where offset_q is a sign-extended, 13-bit signed sum.
REQ-026 If y < 0, m_y SHALL be 0 and clip=1; if y > Y_MAX, m_y SHALL be Y_MAX and clip=1; otherwise m_y = y and clip=0.
REQ-027 The result {x_cnt, y, clip, last} SHALL be written to the FIFO on the same cycle.
REQ-028 Latency from accept to m_valid SHALL be 2 cycles when the FIFO is empty.
REQ-029 Sustained throughput SHALL be 1 sample per cycle while m_ready=1.
REQ-030 x_cnt SHALL increment on each FIFO write.
REQ-031 x_cnt SHALL return to 0 after a write with last=1, or after a write at X_MAX, whichever comes first.
REQ-032 offset_q SHALL load cfg_y_offset on the cycle after a last=1 write, and at reset.
REQ-033 cfg_y_offset changes mid-sweep SHALL have no effect until the next sweep.
REQ-034 The FIFO presents its head on m_x/m_y/m_last/m_clip with m_valid = (fifo_count != 0).
REQ-035 The head is popped when m_valid=1 and m_ready=1.
REQ-036 While m_valid=1 and m_ready=0, all m_* outputs SHALL hold stable.
REQ-037 A simultaneous push and pop SHALL leave fifo_count unchanged, and pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 A push into a full FIFO is impossible by REQ-022; the verification bench SHALL assert that it never occurs.

Reset
REQ-039 On rst=1 at a clk edge, the block SHALL clear v1, fifo_count, pointers, x_cnt and clip.
REQ-040 On the same edge, offset_q SHALL load cfg_y_offset.
REQ-041 During reset and on the first cycle after it: m_valid=0, m_x=0, m_y=0, m_last=0, m_clip=0, s_ready=0.
REQ-042 s_ready SHALL be 1 from the second cycle after reset release.
REQ-043 A reset mid-sweep SHALL discard in-flight and buffered points without emitting any of them.

Structure
REQ-044 ADDR_WIDTH, DATA_WIDTH, Y_MAX, X_MAX, the Q11.4 fraction width (4) and the rounding constant (8) SHALL live in a shared package, y_scale_pkg, which the ROM wrapper also uses.
REQ-045 The output buffer SHALL be one sub-module, y_map_fifo: a synchronous FIFO with count output.
REQ-046 The ROM SHALL remain outside this block, connected at the level above.

Verification
REQ-047 Reset then a single sample with rom_rd_data=0x0500 and offset=0 -> m_valid two cycles after accept, m_y=80, m_x=0, m_clip=0.
REQ-048 ROM word 0x7FFF with offset=+100 -> m_y=1079, m_clip=1; ROM word 0x0010 with offset=-5 -> m_y=0, m_clip=1.
REQ-049 1920 back-to-back samples with m_ready=1 and s_last on the final one -> no s_ready gaps after startup, m_x counts 0..1919, m_last=1 only at x=1919, then x_cnt=0.
REQ-050 m_ready held 0 for 10 cycles mid-stream -> s_ready drops after at most 4 accepted samples, outputs hold stable, no loss or duplication, order preserved.
REQ-051 cfg_y_offset changed from 0 to 50 mid-sweep -> the current sweep stays unshifted and the next sweep is shifted by +50 rows.
REQ-052 rst asserted with 3 points buffered -> next cycle m_valid=0, then the first post-reset point has m_x=0.
